rename_free_list_ctrl: RTL

Free-list controller for the Tomasulo register-renaming stage. Accepts decoded instructions over a valid/ready handshake, hands each destination-writing instruction a free physical tag, and drives the rename table's assign strobe. Takes freed tags back at commit and rewinds allocation on a pipeline flush. Sits between decode and the rename table, ahead of the reservation stations and ROB.

---
 rtl/rename_free_list_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/rename_free_list_ctrl.sv
// Free-list controller for register renaming: hands out free physical tags to
// destination-writing instructions, reclaims tags at commit, rewinds on flush.
module rename_free_list_ctrl #(
    parameter int PREG_W   = 6,
    parameter int AREG_W   = 5,
    parameter int FL_DEPTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic              dec_wr,
    input  logic [AREG_W-1:0] dec_dest,
    output logic              alloc_valid,
    output logic [AREG_W-1:0] alloc_arch,
    output logic [PREG_W-1:0] alloc_phys,
    input  logic              commit_valid,
    input  logic              commit_alloc,
    input  logic [PREG_W-1:0] commit_free_phys,
    input  logic              flush,
    output logic              rt_restore,
    output logic [PREG_W-1:0] free_count,
    output logic [15:0]       stall_cycles
);

    localparam int IDX_W = $clog2(FL_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic {ST_RUN, ST_RECOVER} state_t;

    state_t                         state_q, state_d;
    logic [PTR_W-1:0]               head_q, head_d;
    logic [PTR_W-1:0]               chead_q, chead_d;
    logic [PTR_W-1:0]               tail_q, tail_d;
    logic [15:0]                    stall_q, stall_d;
    logic [FL_DEPTH-1:0][PREG_W-1:0] mem_q, mem_d;

    logic [PTR_W-1:0] occ;
    logic             is_alloc;
    logic             has_free;
    logic             fire;
    logic             alloc_fire;
    logic             commit_do;

    // Pointers carry a wrap bit, so tail - head is the number of free tags
    // and equal pointers unambiguously mean "no free tags".
    assign occ        = tail_q - head_q;
    assign has_free   = (tail_q != head_q);
    assign is_alloc   = dec_wr && (dec_dest != '0);
    assign fire       = dec_valid && dec_ready;
    assign alloc_fire = fire && is_alloc;
    assign commit_do  = commit_valid && commit_alloc;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: every flush (including one during recovery) lands in RECOVER
    always_comb begin
        state_d = ST_RUN;
        if (flush) begin
            state_d = ST_RECOVER;
        end
    end

    // FSM outputs
    always_comb begin
        dec_ready  = 1'b0;
        rt_restore = 1'b0;
        case (state_q)
            ST_RUN: begin
                dec_ready = !flush && (!is_alloc || has_free);
            end
            ST_RECOVER: begin
                rt_restore = 1'b1;
            end
            default: begin
                dec_ready  = 1'b0;
                rt_restore = 1'b0;
            end
        endcase
    end

    assign alloc_valid  = alloc_fire;
    assign alloc_arch   = dec_dest;
    assign alloc_phys   = mem_q[head_q[IDX_W-1:0]];
    assign free_count   = PREG_W'(occ);
    assign stall_cycles = stall_q;

    // Commit is applied before the flush rewind so the restored head already
    // accounts for a tag retired in the flush cycle.
    always_comb begin
        mem_d   = mem_q;
        tail_d  = tail_q;
        chead_d = chead_q;
        if (commit_do) begin
            mem_d[tail_q[IDX_W-1:0]] = commit_free_phys;
            tail_d                   = tail_q + 1'b1;
            chead_d                  = chead_q + 1'b1;
        end

        head_d = head_q;
        if (flush) begin
            head_d = chead_d;
        end else if (alloc_fire) begin
            head_d = head_q + 1'b1;
        end

        stall_d = stall_q;
        if (dec_valid && !dec_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            chead_q <= '0;
            tail_q  <= PTR_W'(FL_DEPTH);
            stall_q <= '0;
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem_q[i] <= PREG_W'(FL_DEPTH + i);
            end
        end else begin
            head_q  <= head_d;
            chead_q <= chead_d;
            tail_q  <= tail_d;
            stall_q <= stall_d;
            mem_q   <= mem_d;
        end
    end

endmodule
